// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small synchronous FIFO.
// Frame format is latched at pop time, so config changes only affect later frames.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DIV_W-1:0]              cfg_divisor,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop1, StStop2} state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 ready_q;

  state_e               state_q;
  logic                 txd_q, busy_q;
  logic [DIV_W-1:0]     cnt_q, div_q;
  logic [DATA_BITS-1:0] data_q;
  logic [BW-1:0]        bit_q;
  logic                 par_en_q, par_bit_q, stop2_q;

  logic                 push, pop, last_stop;
  logic [DATA_BITS-1:0] head;

  assign head      = mem_q[rd_ptr_q];
  assign push      = in_valid && ready_q;
  assign last_stop = (cnt_q == '0) &&
                     ((state_q == StStop1 && !stop2_q) || state_q == StStop2);
  assign pop       = (level_q != '0) && (state_q == StIdle || last_stop);

  always_comb begin
    level_d = level_q;
    if (push && !pop) level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // in_ready is a register so it reads 0 throughout reset and rises one edge later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      ready_q <= (level_d != LW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      div_q     <= '0;
      data_q    <= '0;
      bit_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (pop) begin
      state_q   <= StStart;
      txd_q     <= 1'b0;
      busy_q    <= 1'b1;
      data_q    <= head;
      cnt_q     <= cfg_divisor;
      div_q     <= cfg_divisor;
      bit_q     <= '0;
      par_en_q  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit_q <= (^head) ^ (cfg_parity == 2'b10);
      stop2_q   <= cfg_stop2;
    end else if (state_q != StIdle) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - DIV_W'(1);
      end else begin
        cnt_q <= div_q;
        case (state_q)
          StStart: begin
            state_q <= StData;
            txd_q   <= data_q[0];
          end
          StData: begin
            if (bit_q == BW'(DATA_BITS - 1)) begin
              if (par_en_q) begin
                state_q <= StParity;
                txd_q   <= par_bit_q;
              end else begin
                state_q <= StStop1;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_q  <= bit_q + BW'(1);
              data_q <= data_q >> 1;
              txd_q  <= data_q[1];
            end
          end
          StParity: begin
            state_q <= StStop1;
            txd_q   <= 1'b1;
          end
          StStop1: begin
            if (stop2_q) begin
              state_q <= StStop2;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
            txd_q <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready   = ready_q;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter DIV_W, default 16, width of the baud divisor.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cfg_divisor, input, DIV_W, bit period minus one, in clk cycles.
REQ-007 SHALL have port cfg_parity, input, 2: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 SHALL have port cfg_stop2, input, 1: 0 gives one stop bit, 1 gives two.
REQ-009 SHALL have port in_valid, input, 1, producer offers in_data.
REQ-010 SHALL have port in_ready, output, 1, FIFO can accept a word.
REQ-011 SHALL have port in_data, input, DATA_BITS, word to transmit, LSB first.
REQ-012 SHALL have port txd, output, 1, serial line; idle high.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1, count of words queued, excluding the word in flight.

Function
REQ-015 SHALL accept a push on a rising edge where in_valid and in_ready are both high.
REQ-016 SHALL drive in_ready = (fifo_level != FIFO_DEPTH) from registered state.
- A push is refused when full, even if a pop occurs in the same cycle.
REQ-017 SHALL handle a push and a pop in the same cycle (not full) by leaving fifo_level unchanged and keeping FIFO order.
REQ-018 SHALL use read/write pointers that wrap modulo FIFO_DEPTH without a gap or a lost word.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-020 SHALL, on an edge in IDLE with fifo_level>0:
- pop the head into the shift register;
- latch cfg_divisor, cfg_parity and cfg_stop2 for the whole frame;
- enter START.
REQ-021 SHALL hold each bit for exactly cfg_divisor+1 clk cycles; divisor 0 gives one cycle per bit.
REQ-022 SHALL register txd: 0 in START, data bit in DATA, parity bit in PARITY, 1 in STOP1/STOP2/IDLE.
REQ-023 SHALL send exactly DATA_BITS data bits, LSB first, then:
- PARITY only if the latched parity is 01 or 10, else STOP1;
- STOP2 only if the latched stop2 is 1, else end of frame.
REQ-024 SHALL set the parity bit to XOR of the data bits (even) or its inverse (odd).
REQ-025 SHALL, at the end of the last stop bit with fifo_level>0, pop and enter START directly with no idle cycle; otherwise enter IDLE.
REQ-026 SHALL give latency: word pushed at edge N into an empty FIFO with FSM IDLE -> pop at edge N+1 -> txd low from edge N+1.
REQ-027 SHALL ignore cfg_* changes during a frame; they take effect at the next pop.

Reset
REQ-028 SHALL, while resetn is low, asynchronously force:
- FSM to IDLE, txd=1, busy=0;
- FIFO empty (fifo_level=0) with pointers at 0;
- in_ready=0.
REQ-029 SHALL assert in_ready=1 on the first rising edge after resetn deasserts.
REQ-030 SHALL, on reset mid-frame, return txd high immediately, abandon the frame and discard all queued words.

Verification
REQ-031 SHALL cover a single frame: DATA_BITS=8, divisor 3, parity 00, stop2 0, push 0x55 -> txd 0,1,0,1,0,1,0,1,0,1, 4 clks each, then idle; busy high for 40 clks.
REQ-032 SHALL cover parity and two stop bits: parity 10, stop2 1, push 0x07 -> parity bit 0 (three ones, odd), then two stop bits; frame length 12 bit-times.
REQ-033 SHALL cover full/back-to-back: push 5 words with FIFO_DEPTH=4 while the first is in flight -> in_ready low at level 4, all 5 frames sent in order with no idle gap between stop and start.
REQ-034 SHALL cover a config change mid-frame: cfg_divisor 3 -> 7 during DATA -> current frame stays at 4 clks/bit, next frame at 8 clks/bit.
REQ-035 SHALL cover reset mid-frame: resetn low during data bit 3 with 2 words queued -> txd=1 and fifo_level=0 without a clock edge; after release, no frame is sent.
REQ-036 SHALL cover wrap and simultaneous push/pop: 20 words streamed with in_valid held high -> pointers wrap, level never exceeds 4, output order matches input.
